// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI-Lite round-robin arbiter.
package axil_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_arb_rr_arb.sv
// Combinational round-robin pick: lowest requester at or above ptr wins,
// otherwise wrap around to the lowest requester overall.
module rr_arb #(
   parameter  int NUM_REQ = 2,
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt
);

   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] masked;

   // Isolate the lowest set bit of the masked vector, falling back to the raw one.
   always_comb begin
      mask   = {NUM_REQ{1'b1}} << ptr;
      masked = req & mask;
      if (|masked) gnt = masked & (~masked + NUM_REQ'(1));
      else         gnt = req & (~req + NUM_REQ'(1));
   end

endmodule

// File: rtl/axil_arb.sv
// N-to-1 AXI-Lite arbiter; write and read paths each own one transaction at a time.
module axil_arb
   import axil_arb_pkg::*;
#(
   parameter int NUM_SRCS   = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_SRCS-1:0][ADDR_WIDTH-1:0]   src_axi_awaddr,
   input  logic [NUM_SRCS-1:0]                   src_axi_awvalid,
   output logic [NUM_SRCS-1:0]                   src_axi_awready,
   input  logic [NUM_SRCS-1:0][DATA_WIDTH-1:0]   src_axi_wdata,
   input  logic [NUM_SRCS-1:0][STRB_WIDTH-1:0]   src_axi_wstrb,
   input  logic [NUM_SRCS-1:0]                   src_axi_wvalid,
   output logic [NUM_SRCS-1:0]                   src_axi_wready,
   output logic [NUM_SRCS-1:0][1:0]              src_axi_bresp,
   output logic [NUM_SRCS-1:0]                   src_axi_bvalid,
   input  logic [NUM_SRCS-1:0]                   src_axi_bready,
   input  logic [NUM_SRCS-1:0][ADDR_WIDTH-1:0]   src_axi_araddr,
   input  logic [NUM_SRCS-1:0]                   src_axi_arvalid,
   output logic [NUM_SRCS-1:0]                   src_axi_arready,
   output logic [NUM_SRCS-1:0][DATA_WIDTH-1:0]   src_axi_rdata,
   output logic [NUM_SRCS-1:0][1:0]              src_axi_rresp,
   output logic [NUM_SRCS-1:0]                   src_axi_rvalid,
   input  logic [NUM_SRCS-1:0]                   src_axi_rready,
   output logic [ADDR_WIDTH-1:0]                 dst_axi_awaddr,
   output logic                                  dst_axi_awvalid,
   input  logic                                  dst_axi_awready,
   output logic [DATA_WIDTH-1:0]                 dst_axi_wdata,
   output logic [STRB_WIDTH-1:0]                 dst_axi_wstrb,
   output logic                                  dst_axi_wvalid,
   input  logic                                  dst_axi_wready,
   input  logic [1:0]                            dst_axi_bresp,
   input  logic                                  dst_axi_bvalid,
   output logic                                  dst_axi_bready,
   output logic [ADDR_WIDTH-1:0]                 dst_axi_araddr,
   output logic                                  dst_axi_arvalid,
   input  logic                                  dst_axi_arready,
   input  logic [DATA_WIDTH-1:0]                 dst_axi_rdata,
   input  logic [1:0]                            dst_axi_rresp,
   input  logic                                  dst_axi_rvalid,
   output logic                                  dst_axi_rready,
   output logic [NUM_SRCS-1:0]                   wr_grant,
   output logic [NUM_SRCS-1:0]                   rd_grant
);

   localparam int PTR_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRCS - 1);

   arb_state_e          wr_state_q, wr_state_d, rd_state_q, rd_state_d;
   logic [NUM_SRCS-1:0] wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [NUM_SRCS-1:0] wr_req, rd_req, wr_pick, rd_pick;
   logic [PTR_W-1:0]    wr_idx, rd_idx;

   assign wr_req = src_axi_awvalid | src_axi_wvalid;
   assign rd_req = src_axi_arvalid;

   rr_arb #(.NUM_REQ(NUM_SRCS)) u_wr_rr (.req(wr_req), .ptr(wr_ptr_q), .gnt(wr_pick));
   rr_arb #(.NUM_REQ(NUM_SRCS)) u_rd_rr (.req(rd_req), .ptr(rd_ptr_q), .gnt(rd_pick));

   // One-hot grant to index; an empty grant selects source 0 for the data muxes.
   always_comb begin
      wr_idx = '0;
      rd_idx = '0;
      for (int i = 0; i < NUM_SRCS; i++) begin
         if (wr_gnt_q[i]) wr_idx = PTR_W'(i);
         if (rd_gnt_q[i]) rd_idx = PTR_W'(i);
      end
   end

   assign dst_axi_awaddr = src_axi_awaddr[wr_idx];
   assign dst_axi_wdata  = src_axi_wdata[wr_idx];
   assign dst_axi_wstrb  = src_axi_wstrb[wr_idx];
   assign dst_axi_araddr = src_axi_araddr[rd_idx];
   assign src_axi_bresp  = {NUM_SRCS{dst_axi_bresp}};
   assign src_axi_rresp  = {NUM_SRCS{dst_axi_rresp}};
   assign src_axi_rdata  = {NUM_SRCS{dst_axi_rdata}};
   assign wr_grant       = wr_gnt_q;
   assign rd_grant       = rd_gnt_q;

   // Write path: arbitration, AW/W forwarding with per-channel done flags, B return.
   always_comb begin
      wr_state_d      = wr_state_q;
      wr_gnt_d        = wr_gnt_q;
      wr_ptr_d        = wr_ptr_q;
      aw_done_d       = aw_done_q;
      w_done_d        = w_done_q;
      dst_axi_awvalid = 1'b0;
      dst_axi_wvalid  = 1'b0;
      dst_axi_bready  = 1'b0;
      src_axi_awready = '0;
      src_axi_wready  = '0;
      src_axi_bvalid  = '0;
      unique case (wr_state_q)
         ARB_IDLE: begin
            if (|wr_req) begin
               wr_gnt_d   = wr_pick;
               wr_state_d = ARB_ADDR;
            end
         end
         ARB_ADDR: begin
            dst_axi_awvalid = !aw_done_q && src_axi_awvalid[wr_idx];
            dst_axi_wvalid  = !w_done_q && src_axi_wvalid[wr_idx];
            src_axi_awready = (!aw_done_q && dst_axi_awready) ? wr_gnt_q : '0;
            src_axi_wready  = (!w_done_q && dst_axi_wready) ? wr_gnt_q : '0;
            aw_done_d       = aw_done_q | (dst_axi_awvalid & dst_axi_awready);
            w_done_d        = w_done_q | (dst_axi_wvalid & dst_axi_wready);
            if (aw_done_d && w_done_d) wr_state_d = ARB_RESP;
         end
         ARB_RESP: begin
            dst_axi_bready = src_axi_bready[wr_idx];
            src_axi_bvalid = dst_axi_bvalid ? wr_gnt_q : '0;
            if (dst_axi_bvalid && dst_axi_bready) begin
               wr_state_d = ARB_IDLE;
               wr_gnt_d   = '0;
               wr_ptr_d   = (wr_idx == LAST_IDX) ? '0 : wr_idx + PTR_W'(1);
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
            end
         end
         default: wr_state_d = ARB_IDLE;
      endcase
   end

   // Read path: arbitration, AR forwarding, R return.
   always_comb begin
      rd_state_d      = rd_state_q;
      rd_gnt_d        = rd_gnt_q;
      rd_ptr_d        = rd_ptr_q;
      dst_axi_arvalid = 1'b0;
      dst_axi_rready  = 1'b0;
      src_axi_arready = '0;
      src_axi_rvalid  = '0;
      unique case (rd_state_q)
         ARB_IDLE: begin
            if (|rd_req) begin
               rd_gnt_d   = rd_pick;
               rd_state_d = ARB_ADDR;
            end
         end
         ARB_ADDR: begin
            dst_axi_arvalid = src_axi_arvalid[rd_idx];
            src_axi_arready = dst_axi_arready ? rd_gnt_q : '0;
            if (dst_axi_arvalid && dst_axi_arready) rd_state_d = ARB_RESP;
         end
         ARB_RESP: begin
            dst_axi_rready = src_axi_rready[rd_idx];
            src_axi_rvalid = dst_axi_rvalid ? rd_gnt_q : '0;
            if (dst_axi_rvalid && dst_axi_rready) begin
               rd_state_d = ARB_IDLE;
               rd_gnt_d   = '0;
               rd_ptr_d   = (rd_idx == LAST_IDX) ? '0 : rd_idx + PTR_W'(1);
            end
         end
         default: rd_state_d = ARB_IDLE;
      endcase
   end

   // State, grant, pointer and done-flag registers for both paths.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state_q <= ARB_IDLE;
         rd_state_q <= ARB_IDLE;
         wr_gnt_q   <= '0;
         rd_gnt_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         wr_gnt_q   <= wr_gnt_d;
         rd_gnt_q   <= rd_gnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
      end
   end

endmodule

// File: tb/tb_axil_arb.sv
// Self-checking bench for axil_arb with two sources: directed scenarios plus
// a randomized write-traffic run against a round-robin reference model.
module tb_axil_arb;
   import axil_arb_pkg::*;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0][31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic [N-1:0][3:0]  s_wstrb;
   logic [N-1:0][1:0]  s_bresp, s_rresp;
   logic [N-1:0]       s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [N-1:0]       s_arvalid, s_arready, s_rvalid, s_rready;
   logic [31:0]        d_awaddr, d_wdata, d_araddr, d_rdata;
   logic [3:0]         d_wstrb;
   logic [1:0]         d_bresp, d_rresp;
   logic               d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
   logic               d_arvalid, d_arready, d_rvalid, d_rready;
   logic [N-1:0]       wr_grant, rd_grant;

   int checks = 0;
   int errors = 0;

   axil_arb #(.NUM_SRCS(N), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .src_axi_awaddr(s_awaddr), .src_axi_awvalid(s_awvalid), .src_axi_awready(s_awready),
      .src_axi_wdata(s_wdata), .src_axi_wstrb(s_wstrb), .src_axi_wvalid(s_wvalid),
      .src_axi_wready(s_wready), .src_axi_bresp(s_bresp), .src_axi_bvalid(s_bvalid),
      .src_axi_bready(s_bready), .src_axi_araddr(s_araddr), .src_axi_arvalid(s_arvalid),
      .src_axi_arready(s_arready), .src_axi_rdata(s_rdata), .src_axi_rresp(s_rresp),
      .src_axi_rvalid(s_rvalid), .src_axi_rready(s_rready),
      .dst_axi_awaddr(d_awaddr), .dst_axi_awvalid(d_awvalid), .dst_axi_awready(d_awready),
      .dst_axi_wdata(d_wdata), .dst_axi_wstrb(d_wstrb), .dst_axi_wvalid(d_wvalid),
      .dst_axi_wready(d_wready), .dst_axi_bresp(d_bresp), .dst_axi_bvalid(d_bvalid),
      .dst_axi_bready(d_bready), .dst_axi_araddr(d_araddr), .dst_axi_arvalid(d_arvalid),
      .dst_axi_arready(d_arready), .dst_axi_rdata(d_rdata), .dst_axi_rresp(d_rresp),
      .dst_axi_rvalid(d_rvalid), .dst_axi_rready(d_rready),
      .wr_grant(wr_grant), .rd_grant(rd_grant)
   );

   // Advance one clock; inputs are driven and outputs sampled around the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
      d_awready = 1'b0; d_wready = 1'b0; d_bvalid = 1'b0; d_bresp = RESP_OKAY;
      d_arready = 1'b0; d_rvalid = 1'b0; d_rresp = RESP_OKAY; d_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      s_awaddr[0] = 32'hA000_0000; s_awaddr[1] = 32'hA111_1111;
      s_araddr[0] = 32'hB000_0000; s_araddr[1] = 32'hB111_1111;
      s_wdata[0]  = 32'hC000_0000; s_wdata[1]  = 32'hC111_1111;
      s_wstrb[0]  = 4'h5;          s_wstrb[1]  = 4'hA;
      idle_inputs();
      s_awvalid = 2'b11; s_wvalid = 2'b11; s_arvalid = 2'b11;
      rst_n = 1'b0;
      cyc();
      cyc();
      #1;
      checks++;
      if ({d_awvalid, d_wvalid, d_bready, d_arvalid, d_rready} !== 5'b0) begin
         errors++; $display("FAIL rst_dst_vr: got %b exp 00000",
                            {d_awvalid, d_wvalid, d_bready, d_arvalid, d_rready});
      end
      checks++;
      if ({wr_grant, rd_grant} !== '0) begin
         errors++; $display("FAIL rst_grant: got wr=%b rd=%b exp 0", wr_grant, rd_grant);
      end
      checks++;
      if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== '0) begin
         errors++; $display("FAIL rst_src: got %b exp 0",
                            {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
      end
      checks++;
      if ({d_awaddr, d_araddr, d_wdata, d_wstrb} !== {32'hA000_0000, 32'hB000_0000, 32'hC000_0000, 4'h5}) begin
         errors++; $display("FAIL rst_mux_src0: got aw=%h ar=%h w=%h s=%h", d_awaddr, d_araddr, d_wdata, d_wstrb);
      end
      idle_inputs();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_single_write();
      do_reset();
      d_awready = 1'b1; d_wready = 1'b1;
      s_awaddr[1] = 32'h10; s_wdata[1] = 32'hDEAD_BEEF; s_wstrb[1] = 4'hF;
      s_awvalid = 2'b10; s_wvalid = 2'b10;
      #1;
      checks++;
      if (d_awvalid !== 1'b0 || wr_grant !== 2'b00) begin
         errors++; $display("FAIL sw_idle: got awvalid=%b grant=%b exp 0/00", d_awvalid, wr_grant);
      end
      cyc(); #1;
      checks++;
      if (wr_grant !== 2'b10 || !d_awvalid || !d_wvalid || d_awaddr !== 32'h10 || d_wdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL sw_fwd: got grant=%b v=%b%b addr=%h data=%h exp 10/11/10/deadbeef",
                            wr_grant, d_awvalid, d_wvalid, d_awaddr, d_wdata);
      end
      checks++;
      if (s_awready !== 2'b10 || s_wready !== 2'b10) begin
         errors++; $display("FAIL sw_ready: got aw=%b w=%b exp 10/10", s_awready, s_wready);
      end
      cyc();
      s_awvalid = '0; s_wvalid = '0;
      d_bvalid = 1'b1; d_bresp = RESP_OKAY; s_bready = 2'b10;
      #1;
      checks++;
      if (s_bvalid !== 2'b10 || d_bready !== 1'b1 || s_bresp[1] !== RESP_OKAY || d_awvalid !== 1'b0) begin
         errors++; $display("FAIL sw_resp: got bvalid=%b bready=%b bresp=%b exp 10/1/00", s_bvalid, d_bready, s_bresp[1]);
      end
      cyc();
      d_bvalid = 1'b0; s_bready = '0;
      #1;
      checks++;
      if (wr_grant !== 2'b00 || s_bvalid !== 2'b00) begin
         errors++; $display("FAIL sw_done: got grant=%b bvalid=%b exp 00/00", wr_grant, s_bvalid);
      end
   endtask

   task automatic test_w_before_aw();
      do_reset();
      d_awready = 1'b1; d_wready = 1'b1;
      s_awaddr[0] = 32'h44; s_wdata[0] = 32'hCAFE_0001;
      s_wvalid = 2'b01;
      cyc(); #1;
      checks++;
      if (!d_wvalid || d_awvalid || s_wready !== 2'b01) begin
         errors++; $display("FAIL wb_w_fwd: got wv=%b awv=%b wready=%b exp 1/0/01", d_wvalid, d_awvalid, s_wready);
      end
      for (int k = 0; k < 2; k++) begin
         cyc(); #1;
         checks++;
         if (d_wvalid || s_wready !== 2'b00 || d_awvalid || wr_grant !== 2'b01) begin
            errors++; $display("FAIL wb_w_held: got wv=%b wready=%b awv=%b grant=%b exp 0/00/0/01",
                               d_wvalid, s_wready, d_awvalid, wr_grant);
         end
      end
      cyc();
      s_awvalid = 2'b01;
      #1;
      checks++;
      if (!d_awvalid || d_awaddr !== 32'h44 || wr_grant !== 2'b01) begin
         errors++; $display("FAIL wb_aw: got awv=%b addr=%h grant=%b exp 1/44/01", d_awvalid, d_awaddr, wr_grant);
      end
      cyc();
      s_awvalid = '0; s_wvalid = '0; d_bvalid = 1'b1; s_bready = 2'b01;
      #1;
      checks++;
      if (s_bvalid !== 2'b01 || d_awvalid || d_wvalid) begin
         errors++; $display("FAIL wb_resp: got bvalid=%b awv=%b wv=%b exp 01/0/0", s_bvalid, d_awvalid, d_wvalid);
      end
      cyc();
      idle_inputs();
   endtask

   task automatic test_concurrent();
      do_reset();
      d_awready = 1'b1; d_wready = 1'b1; d_arready = 1'b1;
      s_araddr[0] = 32'h20; s_arvalid = 2'b01;
      s_awaddr[1] = 32'h30; s_wdata[1] = 32'h0BAD_F00D; s_awvalid = 2'b10; s_wvalid = 2'b10;
      cyc(); #1;
      checks++;
      if (rd_grant !== 2'b01 || wr_grant !== 2'b10 || !d_arvalid || d_araddr !== 32'h20 || d_awaddr !== 32'h30) begin
         errors++; $display("FAIL cc_grant: got rd=%b wr=%b arv=%b ar=%h aw=%h exp 01/10/1/20/30",
                            rd_grant, wr_grant, d_arvalid, d_araddr, d_awaddr);
      end
      cyc();
      s_arvalid = '0; s_awvalid = '0; s_wvalid = '0;
      d_rvalid = 1'b1; d_rdata = 32'h1234_5678; d_rresp = RESP_SLVERR; d_bvalid = 1'b1;
      s_rready = 2'b11; s_bready = 2'b11;
      #1;
      checks++;
      if (s_rvalid !== 2'b01 || s_rdata[0] !== 32'h1234_5678 || s_rresp[0] !== RESP_SLVERR || !d_rready) begin
         errors++; $display("FAIL cc_rdata: got rvalid=%b rdata=%h rresp=%b rready=%b exp 01/12345678/10/1",
                            s_rvalid, s_rdata[0], s_rresp[0], d_rready);
      end
      checks++;
      if (s_bvalid !== 2'b10 || !d_bready) begin
         errors++; $display("FAIL cc_bresp: got bvalid=%b bready=%b exp 10/1", s_bvalid, d_bready);
      end
      cyc();
      idle_inputs();
      #1;
      checks++;
      if (rd_grant !== 2'b00 || wr_grant !== 2'b00) begin
         errors++; $display("FAIL cc_done: got rd=%b wr=%b exp 00/00", rd_grant, wr_grant);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      d_awready = 1'b1; d_wready = 1'b1;
      s_awvalid = 2'b01; s_wvalid = 2'b01;
      cyc();
      cyc();
      s_awvalid = 2'b10; s_wvalid = 2'b10;
      d_bvalid = 1'b1; s_bready = 2'b00;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (d_bready || wr_grant !== 2'b01 || s_bvalid !== 2'b01 || s_awready !== 2'b00) begin
            errors++; $display("FAIL bp_hold: got bready=%b grant=%b bvalid=%b awready=%b exp 0/01/01/00",
                               d_bready, wr_grant, s_bvalid, s_awready);
         end
         cyc();
      end
      s_bready = 2'b01;
      #1;
      checks++;
      if (!d_bready) begin
         errors++; $display("FAIL bp_release: got bready=%b exp 1", d_bready);
      end
      cyc();
      d_bvalid = 1'b0; s_bready = '0;
      #1;
      checks++;
      if (wr_grant !== 2'b00) begin
         errors++; $display("FAIL bp_idle: got grant=%b exp 00", wr_grant);
      end
      cyc(); #1;
      checks++;
      if (wr_grant !== 2'b10) begin
         errors++; $display("FAIL bp_next: got grant=%b exp 10", wr_grant);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      d_awready = 1'b1; d_wready = 1'b1;
      s_awvalid = 2'b01; s_wvalid = 2'b01;
      cyc();
      cyc();
      s_awvalid = '0; s_wvalid = '0; d_bvalid = 1'b1; s_bready = 2'b01;
      cyc();
      d_bvalid = 1'b0; s_bready = '0;
      d_wready = 1'b0;
      s_awvalid = 2'b10; s_wvalid = 2'b10;
      cyc(); #1;
      checks++;
      if (wr_grant !== 2'b10 || !d_awvalid) begin
         errors++; $display("FAIL rm_grant1: got grant=%b awv=%b exp 10/1", wr_grant, d_awvalid);
      end
      cyc();
      s_awvalid = '0;
      #1;
      checks++;
      if (d_awvalid || !d_wvalid) begin
         errors++; $display("FAIL rm_awdone: got awv=%b wv=%b exp 0/1", d_awvalid, d_wvalid);
      end
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      s_wvalid = '0;
      #1;
      checks++;
      if (wr_grant !== 2'b00 || d_awvalid || d_wvalid || s_awready !== 2'b00 || s_wready !== 2'b00) begin
         errors++; $display("FAIL rm_reset: got grant=%b awv=%b wv=%b exp 00/0/0", wr_grant, d_awvalid, d_wvalid);
      end
      s_awvalid = 2'b11; s_wvalid = 2'b11; d_wready = 1'b1;
      cyc(); #1;
      checks++;
      if (wr_grant !== 2'b01 || !d_awvalid || !d_wvalid) begin
         errors++; $display("FAIL rm_fresh: got grant=%b awv=%b wv=%b exp 01/1/1", wr_grant, d_awvalid, d_wvalid);
      end
      idle_inputs();
   endtask

   // Random write traffic from both sources with a randomly stalling downstream.
   task automatic test_random_writes();
      logic [N-1:0]       busy, prev_req, prev_gnt, exp_g, aw_hs, w_hs, b_hs;
      logic [N-1:0][31:0] exp_addr, exp_data;
      logic               got_aw, got_w, db_hs;
      int                 mptr, g;
      int                 done [N];
      do_reset();
      busy = '0; prev_req = '0; prev_gnt = '0; aw_hs = '0; w_hs = '0; b_hs = '0;
      got_aw = 1'b0; got_w = 1'b0; db_hs = 1'b0; mptr = 0;
      exp_addr = '0; exp_data = '0;
      for (int i = 0; i < N; i++) done[i] = 0;
      for (int c = 0; c < 600; c++) begin
         s_awvalid = s_awvalid & ~aw_hs;
         s_wvalid  = s_wvalid & ~w_hs;
         busy      = busy & ~b_hs;
         if (db_hs) begin d_bvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0; end
         for (int i = 0; i < N; i++) begin
            if (!busy[i] && $urandom_range(2) == 0) begin
               busy[i] = 1'b1;
               exp_addr[i] = $urandom; exp_data[i] = $urandom;
               s_awaddr[i] = exp_addr[i]; s_wdata[i] = exp_data[i];
               s_awvalid[i] = 1'b1; s_wvalid[i] = 1'b1;
            end
         end
         s_bready  = N'($urandom);
         d_awready = ($urandom_range(1) == 1);
         d_wready  = ($urandom_range(1) == 1);
         if (got_aw && got_w && !d_bvalid) begin
            d_bvalid = 1'b1;
            d_bresp  = ($urandom_range(1) == 1) ? RESP_SLVERR : RESP_OKAY;
         end
         #1;
         if (wr_grant !== '0 && prev_gnt === '0) begin
            exp_g = '0;
            for (int k = 0; k < N; k++) begin
               if (exp_g == '0 && prev_req[(mptr + k) % N]) exp_g[(mptr + k) % N] = 1'b1;
            end
            checks++;
            if (wr_grant !== exp_g) begin
               errors++; $display("FAIL rnd_grant: cycle %0d got %b exp %b", c, wr_grant, exp_g);
            end
            for (int j = 0; j < N; j++) if (exp_g[j]) mptr = (j + 1) % N;
         end
         checks++;
         if (((s_awready | s_wready | s_bvalid) & ~wr_grant) !== '0) begin
            errors++; $display("FAIL rnd_isolate: cycle %0d got awr=%b wr=%b bv=%b grant=%b",
                               c, s_awready, s_wready, s_bvalid, wr_grant);
         end
         g = 0;
         for (int j = 0; j < N; j++) if (wr_grant[j]) g = j;
         aw_hs = s_awvalid & s_awready;
         w_hs  = s_wvalid & s_wready;
         if (d_awvalid && d_awready) begin
            checks++;
            if (d_awaddr !== exp_addr[g]) begin
               errors++; $display("FAIL rnd_awaddr: cycle %0d got %h exp %h", c, d_awaddr, exp_addr[g]);
            end
            got_aw = 1'b1;
         end
         if (d_wvalid && d_wready) begin
            checks++;
            if (d_wdata !== exp_data[g]) begin
               errors++; $display("FAIL rnd_wdata: cycle %0d got %h exp %h", c, d_wdata, exp_data[g]);
            end
            got_w = 1'b1;
         end
         db_hs = d_bvalid && d_bready;
         b_hs  = s_bvalid & s_bready;
         if (db_hs || b_hs != '0) begin
            checks++;
            if (!db_hs || b_hs !== wr_grant || s_bresp[g] !== d_bresp) begin
               errors++; $display("FAIL rnd_bresp: cycle %0d got dst_hs=%b src_hs=%b bresp=%b exp 1/%b/%b",
                                  c, db_hs, b_hs, s_bresp[g], wr_grant, d_bresp);
            end
            done[g]++;
         end
         prev_req = s_awvalid | s_wvalid;
         prev_gnt = wr_grant;
         cyc();
      end
      checks++;
      if (done[0] < 5 || done[1] < 5) begin
         errors++; $display("FAIL rnd_progress: got done0=%0d done1=%0d exp >=5 each", done[0], done[1]);
      end
      idle_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach the end, exp completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_single_write();
      test_w_before_aw();
      test_concurrent();
      test_backpressure();
      test_reset_mid();
      test_random_writes();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
